// File: rtl/cavlc_pkg.sv
// Shared CAVLC types and the run_before VLC table.
// rb_vlc returns {len, bits}; len==0 marks a pair with no code.
package cavlc_pkg;

   localparam int MAX_RB_LEN = 11;

   typedef enum logic [1:0] {
      RB_IDLE,
      RB_ENC,
      RB_DONE
   } rb_state_e;

   // zl values of 7 and above all select the ">6" column
   function automatic logic [MAX_RB_LEN+3:0] rb_vlc(
      input logic [3:0] run,
      input logic [3:0] zl
   );
      logic [3:0]            len;
      logic [MAX_RB_LEN-1:0] bits;
      len  = '0;
      bits = '0;
      unique case (1'b1)
         (zl == 4'd0): begin
            len  = '0;
            bits = '0;
         end
         (zl == 4'd1): begin
            if (run <= 4'd1) begin
               len  = 4'd1;
               bits = {10'b0, ~run[0]};
            end
         end
         (zl == 4'd2): begin
            case (run)
               4'd0: begin len = 4'd1; bits = 11'd1; end
               4'd1: begin len = 4'd2; bits = 11'd1; end
               4'd2: begin len = 4'd2; bits = 11'd0; end
               default: ;
            endcase
         end
         (zl == 4'd3): begin
            if (run <= 4'd3) begin
               len  = 4'd2;
               bits = {9'b0, ~run[1:0]};
            end
         end
         (zl == 4'd4): begin
            case (run)
               4'd0, 4'd1, 4'd2: begin
                  len  = 4'd2;
                  bits = {9'b0, ~run[1:0]};
               end
               4'd3: begin len = 4'd3; bits = 11'd1; end
               4'd4: begin len = 4'd3; bits = 11'd0; end
               default: ;
            endcase
         end
         (zl == 4'd5): begin
            case (run)
               4'd0: begin len = 4'd2; bits = 11'd3; end
               4'd1: begin len = 4'd2; bits = 11'd2; end
               4'd2, 4'd3, 4'd4, 4'd5: begin
                  len  = 4'd3;
                  bits = 11'(4'd5 - run);
               end
               default: ;
            endcase
         end
         (zl == 4'd6): begin
            case (run)
               4'd0: begin len = 4'd2; bits = 11'd3; end
               4'd1: begin len = 4'd3; bits = 11'd0; end
               4'd2: begin len = 4'd3; bits = 11'd1; end
               4'd3: begin len = 4'd3; bits = 11'd3; end
               4'd4: begin len = 4'd3; bits = 11'd2; end
               4'd5: begin len = 4'd3; bits = 11'd5; end
               4'd6: begin len = 4'd3; bits = 11'd4; end
               default: ;
            endcase
         end
         (zl >= 4'd7): begin
            if (run <= 4'd6) begin
               len  = 4'd3;
               bits = 11'(4'd7 - run);
            end else if (run <= 4'd14) begin
               // run 7..14: a single 1 preceded by run-4 zeros
               len  = run - 4'd3;
               bits = 11'd1;
            end
         end
      endcase
      return {len, bits};
   endfunction

endpackage

// File: rtl/cavlc_rb_lut.sv
// Combinational run_before code lookup around rb_vlc.
// bad flags run>zl or a pair that has no code.
module cavlc_rb_lut
   import cavlc_pkg::*;
#(
   parameter int CNT_W = 5
) (
   input  logic [CNT_W-1:0]      run,
   input  logic [CNT_W-1:0]      zl,
   output logic [MAX_RB_LEN-1:0] bits,
   output logic [3:0]            len,
   output logic                  bad
);

   logic [3:0] run_s;
   logic [3:0] zl_s;

   always_comb begin
      run_s = (int'(run) > 15) ? 4'd15 : 4'(run);
      zl_s  = (int'(zl) > 7) ? 4'd7 : 4'(zl);
      {len, bits} = rb_vlc(run_s, zl_s);
      bad = (run > zl) || (len == 4'd0);
   end

endmodule

// File: rtl/cavlc_run_before_enc.sv
// Streaming CAVLC run_before encoder, one run coded per cycle.
// Define RUN_BEFORE_ERR_CHECK_EN to build descriptor checking on out_err.
module cavlc_run_before_enc
   import cavlc_pkg::*;
#(
   parameter  int MAX_COEF = 16,
   parameter  int CODE_W   = 32,
   localparam int CNT_W    = $clog2(MAX_COEF + 1),
   localparam int LEN_W    = $clog2(CODE_W + 1)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CNT_W-1:0]          in_total_coeff,
   input  logic [CNT_W-1:0]          in_total_zeros,
   input  logic [MAX_COEF*CNT_W-1:0] in_runs,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CODE_W-1:0]         out_code,
   output logic [LEN_W-1:0]          out_len,
   output logic                      out_err
);

   localparam int SUM_W = LEN_W + 1;

   rb_state_e state_q, state_d;

   logic [CNT_W-1:0]          tc_q;
   logic [CNT_W-1:0]          zl_q;
   logic [CNT_W-1:0]          idx_q;
   logic [MAX_COEF*CNT_W-1:0] runs_q;
   logic [CODE_W-1:0]         code_q;
   logic [LEN_W-1:0]          len_q;

   logic                  accept;
   logic                  skip;
   logic [CNT_W-1:0]      tc_clamp;
   logic [CNT_W-1:0]      run_cur;
   logic [MAX_RB_LEN-1:0] vlc_bits;
   logic [3:0]            vlc_len;
   logic                  vlc_bad;
   logic [SUM_W-1:0]      len_sum;
   logic                  ovf;
   logic [CNT_W-1:0]      zl_next;
   logic                  last;
   logic                  enc_exit;

   assign accept = in_valid && in_ready;
   assign skip   = (in_total_coeff <= CNT_W'(1)) ||
                   (in_total_zeros == '0);

   // an oversized count is clamped so idx never leaves the run array
   assign tc_clamp = (int'(in_total_coeff) > MAX_COEF) ?
                     CNT_W'(MAX_COEF) : in_total_coeff;

   always_comb begin
      run_cur = '0;
      for (int i = 0; i < MAX_COEF; i++) begin
         if (idx_q == CNT_W'(i)) run_cur = runs_q[i*CNT_W +: CNT_W];
      end
   end

   cavlc_rb_lut #(
      .CNT_W(CNT_W)
   ) u_lut (
      .run  (run_cur),
      .zl   (zl_q),
      .bits (vlc_bits),
      .len  (vlc_len),
      .bad  (vlc_bad)
   );

   assign len_sum  = {1'b0, len_q} + SUM_W'(vlc_len);
   assign ovf      = len_sum > SUM_W'(CODE_W);
   assign zl_next  = vlc_bad ? '0 : zl_q - run_cur;
   assign last     = idx_q == (tc_q - CNT_W'(2));
   assign enc_exit = last || (zl_next == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= RB_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         RB_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = skip ? RB_DONE : RB_ENC;
         end
         RB_ENC: begin
            if (enc_exit) state_d = RB_DONE;
         end
         RB_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = RB_IDLE;
         end
         default: state_d = RB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tc_q   <= '0;
         zl_q   <= '0;
         idx_q  <= '0;
         runs_q <= '0;
         code_q <= '0;
         len_q  <= '0;
      end else if (accept) begin
         tc_q   <= tc_clamp;
         zl_q   <= in_total_zeros;
         idx_q  <= '0;
         runs_q <= in_runs;
         code_q <= '0;
         len_q  <= '0;
      end else if (state_q == RB_ENC) begin
         // illegal runs and overflowing steps add no bits
         if (!vlc_bad && !ovf) begin
            code_q <= (code_q << vlc_len) | CODE_W'(vlc_bits);
            len_q  <= len_sum[LEN_W-1:0];
         end
         zl_q  <= zl_next;
         idx_q <= idx_q + CNT_W'(1);
      end
   end

   assign out_code = code_q;
   assign out_len  = len_q;

`ifdef RUN_BEFORE_ERR_CHECK_EN
   logic err_q;
   logic hdr_err;

   assign hdr_err = (int'(in_total_coeff) > MAX_COEF) ||
                    (int'(in_total_coeff) + int'(in_total_zeros) > MAX_COEF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 err_q <= 1'b0;
      else if (accept)            err_q <= hdr_err;
      else if (state_q == RB_ENC) err_q <= err_q | vlc_bad | ovf;
   end

   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule
